// File: rtl/pin_io_stage.sv
// Pad-side I/O stage: input synchroniser, per-pin deglitch filter, edge flags, registered pad outputs.
// Optional filter counters are built only when PIN_IO_FILTER_EN is defined.
module pin_io_stage #(
  parameter int unsigned PINS        = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_BITS   = 4
) (
  input  logic                 clk_cog,
  input  logic                 nres,
  input  logic [PINS-1:0]      pad_in,
  input  logic [FILT_BITS-1:0] filt_len,
  output logic [PINS-1:0]      pin_in,
  output logic [PINS-1:0]      edge_rise,
  output logic [PINS-1:0]      edge_fall,
  input  logic [PINS-1:0]      pin_out,
  input  logic [PINS-1:0]      pin_dir,
  output logic [PINS-1:0]      pad_out,
  output logic [PINS-1:0]      pad_oe
);

  logic [PINS-1:0] r_sync [SYNC_STAGES];
  logic [PINS-1:0] r_pin_in;
  logic [PINS-1:0] r_rise;
  logic [PINS-1:0] r_fall;
  logic [PINS-1:0] r_pad_out;
  logic [PINS-1:0] r_pad_oe;
  logic [PINS-1:0] w_s;
  logic [PINS-1:0] w_pin_next;

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= pad_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef PIN_IO_FILTER_EN
  logic [FILT_BITS-1:0] r_cnt      [PINS];
  logic [FILT_BITS-1:0] w_cnt_next [PINS];
  logic [FILT_BITS:0]   w_inc      [PINS];

  // Compare is one bit wider so cnt+1 can never alias to zero.
  always_comb begin
    w_pin_next = r_pin_in;
    for (int unsigned i = 0; i < PINS; i++) begin
      w_cnt_next[i] = '0;
      w_inc[i]      = {1'b0, r_cnt[i]} + {{FILT_BITS{1'b0}}, 1'b1};
      if (w_s[i] != r_pin_in[i]) begin
        if (w_inc[i] >= {1'b0, filt_len}) w_pin_next[i] = w_s[i];
        else                              w_cnt_next[i] = w_inc[i][FILT_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      for (int unsigned i = 0; i < PINS; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < PINS; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end
`else
  logic w_unused_filt_len;
  assign w_unused_filt_len = ^filt_len;
  assign w_pin_next        = w_s;
`endif

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      r_pin_in  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_pad_out <= '0;
      r_pad_oe  <= '0;
    end else begin
      r_pin_in  <= w_pin_next;
      r_rise    <= w_pin_next & ~r_pin_in;
      r_fall    <= ~w_pin_next & r_pin_in;
      r_pad_out <= pin_out;
      r_pad_oe  <= pin_dir;
    end
  end

  assign pin_in    = r_pin_in;
  assign edge_rise = r_rise;
  assign edge_fall = r_fall;
  assign pad_out   = r_pad_out;
  assign pad_oe    = r_pad_oe;

endmodule

// File: tb/tb_pin_io_stage.sv
// Self-checking bench for pin_io_stage: directed latency/filter/reset steps plus randomized traffic
// checked every cycle against a queue-based behavioural model (honours PIN_IO_FILTER_EN).
module tb_pin_io_stage;

  localparam int PINS = 32;
  localparam int SYNC = 2;
  localparam int FB   = 4;
`ifdef PIN_IO_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic            clk_cog = 1'b0;
  logic            nres;
  logic [PINS-1:0] pad_in, pin_out, pin_dir;
  logic [FB-1:0]   filt_len;
  logic [PINS-1:0] pin_in, edge_rise, edge_fall, pad_out, pad_oe;

  int n_cmp = 0;
  int n_err = 0;

  pin_io_stage #(.PINS(PINS), .SYNC_STAGES(SYNC), .FILT_BITS(FB)) dut (
    .clk_cog(clk_cog), .nres(nres), .pad_in(pad_in), .filt_len(filt_len),
    .pin_in(pin_in), .edge_rise(edge_rise), .edge_fall(edge_fall),
    .pin_out(pin_out), .pin_dir(pin_dir), .pad_out(pad_out), .pad_oe(pad_oe)
  );

  always #5 clk_cog = ~clk_cog;

  // Behavioural model: synchroniser is a delay queue, filter is the per-pin counting rule.
  logic [PINS-1:0] q_sync [$];
  logic [PINS-1:0] m_pin, m_rise, m_fall, m_out, m_oe;
  int              m_cnt [PINS];

  task automatic model_reset();
    q_sync.delete();
    for (int k = 0; k < SYNC; k++) q_sync.push_back('0);
    m_pin = '0; m_rise = '0; m_fall = '0; m_out = '0; m_oe = '0;
    for (int i = 0; i < PINS; i++) m_cnt[i] = 0;
  endtask

  task automatic model_clock();
    logic [PINS-1:0] s, nxt;
    s   = q_sync[0];
    nxt = m_pin;
    for (int i = 0; i < PINS; i++) begin
      if (!FILT_EN) nxt[i] = s[i];
      else if (s[i] == m_pin[i]) m_cnt[i] = 0;
      else if (m_cnt[i] + 1 >= int'(filt_len)) begin nxt[i] = s[i]; m_cnt[i] = 0; end
      else m_cnt[i] = m_cnt[i] + 1;
    end
    m_rise = nxt & ~m_pin;
    m_fall = ~nxt & m_pin;
    m_pin  = nxt;
    q_sync.push_back(pad_in);
    void'(q_sync.pop_front());
    m_out = pin_out;
    m_oe  = pin_dir;
  endtask

  task automatic chk(input string tag, input logic [PINS-1:0] obs, input logic [PINS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pin_in",    pin_in,    m_pin);
    chk("edge_rise", edge_rise, m_rise);
    chk("edge_fall", edge_fall, m_fall);
    chk("pad_out",   pad_out,   m_out);
    chk("pad_oe",    pad_oe,    m_oe);
  endtask

  task automatic tick();
    @(posedge clk_cog);
    if (nres) model_clock(); else model_reset();
    #1;
    check_all();
    @(negedge clk_cog);
  endtask

  // Counts edges until pin_in[pin] reaches lvl; -1 if it never does within the bound.
  task automatic measure(input int pin, input logic lvl, output int n);
    n = 0;
    do begin tick(); n++; end while (pin_in[pin] !== lvl && n < 40);
    if (pin_in[pin] !== lvl) n = -1;
  endtask

  task automatic async_reset();
    nres = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  int          lat;
  logic [31:0] seen;

  initial begin
    // 1. reset with random inputs
    nres = 1'b0; pad_in = $urandom; pin_out = $urandom; pin_dir = $urandom; filt_len = FB'($urandom);
    model_reset();
    repeat (3) tick();
    pad_in = '0; pin_out = '0; pin_dir = '0; filt_len = '0;
    tick();
    nres = 1'b1;
    repeat (4) tick();

    // 2. no filtering: 3 edges from pad change to pin_in
    pad_in[0] = 1'b1;
    measure(0, 1'b1, lat);
    chk("t2_latency", 32'(lat), 32'd3);
    chk("t2_rise", {31'd0, edge_rise[0]}, 32'd1);
    tick();
    chk("t2_rise_once", {31'd0, edge_rise[0]}, 32'd0);

    // 3. glitch then steady level
    filt_len = 4'd4;
    pad_in[5] = 1'b1;
    repeat (3) tick();
    pad_in[5] = 1'b0;
    seen = '0;
    repeat (8) begin tick(); seen[0] = seen[0] | pin_in[5] | edge_rise[5]; end
    chk("t3_glitch", seen, FILT_EN ? 32'd0 : 32'd1);
    pad_in[5] = 1'b1;
    measure(5, 1'b1, lat);
    chk("t3_latency", 32'(lat), FILT_EN ? 32'd6 : 32'd3);
    pad_in[5] = 1'b0;
    measure(5, 1'b0, lat);
    chk("t3_fall", {31'd0, edge_fall[5]}, 32'd1);

    // 4. output path
    pin_out = 32'hA5A5_1234; pin_dir = 32'hFFFF_0000;
    tick();
    chk("t4_pad_out", pad_out, 32'hA5A5_1234);
    chk("t4_pad_oe",  pad_oe,  32'hFFFF_0000);

    // 5. reset mid-count
    filt_len = 4'd8;
    pad_in[3] = 1'b1;
    repeat (5) tick();
    async_reset();
    tick();
    nres = 1'b1;
    measure(3, 1'b1, lat);
    chk("t5_latency", 32'(lat), FILT_EN ? 32'd10 : 32'd3);

    // 6. long filter setting on pin 31
    filt_len = 4'd15;
    pad_in[31] = 1'b1;
    measure(31, 1'b1, lat);
    pad_in[31] = 1'b0;
    measure(31, 1'b0, lat);
    chk("t6_latency", 32'(lat), FILT_EN ? 32'd17 : 32'd3);
    chk("t6_fall", {31'd0, edge_fall[31]}, 32'd1);

    // randomized traffic with sparse toggles, filter changes and one mid-run reset
    for (int c = 0; c < 600; c++) begin
      pad_in  = pad_in ^ ($urandom & $urandom & $urandom);
      pin_out = $urandom;
      pin_dir = $urandom;
      if ($urandom_range(0, 39) == 0) filt_len = FB'($urandom_range(0, 15));
      if (c == 300) begin
        async_reset();
        tick();
        nres = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
